// File: rtl/hw_io_pkg.sv
// Register map and STATUS field layout shared by the I/O port and its users.
package hw_io_pkg;

    localparam int unsigned IO_ADDR_W = 4;

    localparam logic [IO_ADDR_W-1:0] REG_DATA   = 4'd0;
    localparam logic [IO_ADDR_W-1:0] REG_STATUS = 4'd1;
    localparam int unsigned          REG_DISP_BASE = 2;

    // Bit of the STATUS write data that clears the sticky overflow flag.
    localparam int unsigned STATUS_CLR_OVF_BIT = 0;

    // The STATUS count field occupies bits [clog2(depth):0].
    function automatic int unsigned status_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // The full flag sits directly above the count field.
    function automatic int unsigned status_full_pos(input int unsigned depth);
        return status_cnt_w(depth);
    endfunction

    // The overflow flag sits directly above the full flag.
    function automatic int unsigned status_ovf_pos(input int unsigned depth);
        return status_cnt_w(depth) + 1;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO for captured switch words. A push on a full FIFO is accepted
// only when a pop happens in the same cycle; a pop on an empty FIFO is ignored.
module io_fifo #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head_c,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_count_nxt;

    // Qualify requests against occupancy and compute the next fill level.
    always_comb begin
        w_push      = i_push && (!r_full || i_pop);
        w_pop       = i_pop && !r_empty;
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Storage, wrapping pointers and registered occupancy flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_head_c = r_mem[r_rd_ptr];
    assign o_count  = r_count;
    assign o_full   = r_full;
    assign o_empty  = r_empty;

endmodule

// File: rtl/hw_io_port.sv
// Memory-mapped switch/display port for the 16-bit multicycle core.
// Optional strobe debounce filter: define HW_IO_DEBOUNCE_EN.
module hw_io_port
    import hw_io_pkg::*;
#(
    parameter int unsigned DATA_W          = 16,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned DISPLAYS        = 2,
    parameter int unsigned STROBE_BIT      = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                         Clock,
    input  logic                         ResetButton,
    input  logic [DATA_W-1:0]            HardwareInput,
    input  logic [IO_ADDR_W-1:0]         io_addr,
    input  logic                         io_rd,
    input  logic                         io_wr,
    input  logic [DATA_W-1:0]            io_wdata,
    output logic [DATA_W-1:0]            io_rdata,
    output logic                         InputRecv,
    output logic [DISPLAYS*DATA_W-1:0]   DisplayOutput
);

    localparam int unsigned CNT_W    = status_cnt_w(FIFO_DEPTH);
    localparam int unsigned FULL_POS = status_full_pos(FIFO_DEPTH);
    localparam int unsigned OVF_POS  = status_ovf_pos(FIFO_DEPTH);
    localparam logic [DATA_W-1:0] STROBE_MASK = DATA_W'(1) << STROBE_BIT;

    logic [DATA_W-1:0] r_sync1;
    logic [DATA_W-1:0] r_sync2;
    logic [1:0]        r_settle;
    logic              r_armed;
    logic              r_strobe_prev;
    logic              r_cap_vld;
    logic [DATA_W-1:0] r_cap_data;
    logic              r_ovf;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_disp [DISPLAYS];

    logic              w_strobe_lvl;
    logic              w_pop;
    logic              w_clr_ovf;
    logic              w_drop;
    logic [DATA_W-1:0] w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_status;
    logic [DATA_W-1:0] w_rdata_c;

    // Two-flop synchroniser for the raw switch bank.
    always_ff @(posedge Clock or negedge ResetButton) begin
        if (!ResetButton) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= HardwareInput;
            r_sync2 <= r_sync1;
        end
    end

`ifdef HW_IO_DEBOUNCE_EN
    localparam int unsigned DB_CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_CW-1:0] r_db_cnt;
    logic             r_db_lvl;

    // Filtered strobe follows the synchronised one after DEBOUNCE_CYCLES stable cycles.
    always_ff @(posedge Clock or negedge ResetButton) begin
        if (!ResetButton) begin
            r_db_cnt <= '0;
            r_db_lvl <= 1'b0;
        end else if (r_sync2[STROBE_BIT] != r_db_lvl) begin
            if (r_db_cnt == DB_CW'(DEBOUNCE_CYCLES - 1)) begin
                r_db_lvl <= r_sync2[STROBE_BIT];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_CW'(1);
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_strobe_lvl = r_db_lvl;
`else
    // Filter bypassed; the debounce length only matters in the filtered build.
    assign w_strobe_lvl = r_sync2[STROBE_BIT] | (1'b0 & 1'(DEBOUNCE_CYCLES));
`endif

    // Captures are armed only once the strobe has been seen low after reset,
    // so a strobe switch left high across reset does not produce a capture.
    always_ff @(posedge Clock or negedge ResetButton) begin
        if (!ResetButton) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
        end else if (r_settle != 2'd2) begin
            r_settle <= r_settle + 2'd1;
        end else if (!r_sync2[STROBE_BIT]) begin
            r_armed <= 1'b1;
        end
    end

    // Rising-edge detect on the strobe; the captured word is staged one cycle.
    always_ff @(posedge Clock or negedge ResetButton) begin
        if (!ResetButton) begin
            r_strobe_prev <= 1'b0;
            r_cap_vld     <= 1'b0;
            r_cap_data    <= '0;
        end else begin
            r_strobe_prev <= w_strobe_lvl;
            r_cap_vld     <= w_strobe_lvl && !r_strobe_prev && r_armed;
            r_cap_data    <= r_sync2 & ~STROBE_MASK;
        end
    end

    io_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (Clock),
        .i_rst_n  (ResetButton),
        .i_push   (r_cap_vld),
        .i_data   (r_cap_data),
        .i_pop    (w_pop),
        .o_head_c (w_head),
        .o_count  (w_count),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    // Register window decode and read-data selection.
    always_comb begin
        w_pop     = io_rd && (io_addr == REG_DATA);
        w_clr_ovf = io_wr && (io_addr == REG_STATUS) && io_wdata[STATUS_CLR_OVF_BIT];
        w_drop    = r_cap_vld && w_full && !w_pop;

        w_status              = '0;
        w_status[CNT_W-1:0]   = w_count;
        w_status[FULL_POS]    = w_full;
        w_status[OVF_POS]     = r_ovf;

        w_rdata_c = '0;
        if (io_addr == REG_DATA) begin
            w_rdata_c = w_empty ? '0 : w_head;
        end
        if (io_addr == REG_STATUS) begin
            w_rdata_c = w_status;
        end
        for (int unsigned n = 0; n < DISPLAYS; n++) begin
            if (io_addr == IO_ADDR_W'(REG_DISP_BASE + n)) begin
                w_rdata_c = r_disp[n];
            end
        end
    end

    // Sticky overflow: a drop in the same cycle as a clear leaves it set.
    always_ff @(posedge Clock or negedge ResetButton) begin
        if (!ResetButton) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    // Read data register, updated only by a read request.
    always_ff @(posedge Clock or negedge ResetButton) begin
        if (!ResetButton) begin
            r_rdata <= '0;
        end else if (io_rd) begin
            r_rdata <= w_rdata_c;
        end
    end

    // Display registers loaded by writes to their window slots.
    always_ff @(posedge Clock or negedge ResetButton) begin
        if (!ResetButton) begin
            for (int unsigned n = 0; n < DISPLAYS; n++) begin
                r_disp[n] <= '0;
            end
        end else if (io_wr) begin
            for (int unsigned n = 0; n < DISPLAYS; n++) begin
                if (io_addr == IO_ADDR_W'(REG_DISP_BASE + n)) begin
                    r_disp[n] <= io_wdata;
                end
            end
        end
    end

    for (genvar g = 0; g < DISPLAYS; g++) begin : g_disp_out
        assign DisplayOutput[g*DATA_W +: DATA_W] = r_disp[g];
    end

    assign io_rdata  = r_rdata;
    assign InputRecv = !w_empty;

endmodule

// File: tb/tb_hw_io_port.sv
// Self-checking bench for hw_io_port: directed tables, corner sequences and a
// randomized run against a queue-based model of the port.
module tb_hw_io_port;

    localparam int unsigned DATA_W          = 16;
    localparam int unsigned FIFO_DEPTH      = 4;
    localparam int unsigned DISPLAYS        = 2;
    localparam int unsigned STROBE_BIT      = 5;
    localparam int unsigned DEBOUNCE_CYCLES = 16;
`ifdef HW_IO_DEBOUNCE_EN
    localparam int unsigned CAP_LAT = 3 + DEBOUNCE_CYCLES;
`else
    localparam int unsigned CAP_LAT = 3;
`endif
    localparam int unsigned HOLD = CAP_LAT + 2;

    logic                         Clock;
    logic                         ResetButton;
    logic [DATA_W-1:0]            HardwareInput;
    logic [3:0]                   io_addr;
    logic                         io_rd;
    logic                         io_wr;
    logic [DATA_W-1:0]            io_wdata;
    logic [DATA_W-1:0]            io_rdata;
    logic                         InputRecv;
    logic [DISPLAYS*DATA_W-1:0]   DisplayOutput;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic [31:0] exp_disp;
    } vec_t;

    vec_t tbl[13];

    // Reference model state for the randomized run.
    logic [15:0] mq[$];
    logic        m_ovf;
    logic [15:0] m_disp[2];
    logic [15:0] m_rdata;
    logic [15:0] h[5];
    logic [15:0] r_sw;
    logic        r_rd, r_wr, pend, drop;
    logic [3:0]  r_addr;
    logic [15:0] r_wd;

    hw_io_port #(
        .DATA_W          (DATA_W),
        .FIFO_DEPTH      (FIFO_DEPTH),
        .DISPLAYS        (DISPLAYS),
        .STROBE_BIT      (STROBE_BIT),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .Clock         (Clock),
        .ResetButton   (ResetButton),
        .HardwareInput (HardwareInput),
        .io_addr       (io_addr),
        .io_rd         (io_rd),
        .io_wr         (io_wr),
        .io_wdata      (io_wdata),
        .io_rdata      (io_rdata),
        .InputRecv     (InputRecv),
        .DisplayOutput (DisplayOutput)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_read(input logic [3:0] a);
        io_addr = a;
        io_rd   = 1'b1;
        tick();
        io_rd   = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        io_addr  = a;
        io_wdata = d;
        io_wr    = 1'b1;
        tick();
        io_wr    = 1'b0;
    endtask

    // One full strobe press/release carrying word v.
    task automatic strobe_word(input logic [15:0] v);
        HardwareInput = v | 16'h0020;
        repeat (HOLD) tick();
        HardwareInput = v & 16'hFFDF;
        repeat (HOLD) tick();
    endtask

    initial begin
        tbl[0]  = '{0, 1, 4'd2,  16'h1234, 16'h0004, 32'h0000_1234};
        tbl[1]  = '{0, 1, 4'd3,  16'hBEEF, 16'h0004, 32'hBEEF_1234};
        tbl[2]  = '{1, 0, 4'd3,  16'h0000, 16'hBEEF, 32'hBEEF_1234};
        tbl[3]  = '{1, 0, 4'd2,  16'h0000, 16'h1234, 32'hBEEF_1234};
        tbl[4]  = '{1, 0, 4'd0,  16'h0000, 16'h0000, 32'hBEEF_1234};
        tbl[5]  = '{1, 0, 4'd3,  16'h0000, 16'hBEEF, 32'hBEEF_1234};
        tbl[6]  = '{1, 0, 4'd15, 16'h0000, 16'h0000, 32'hBEEF_1234};
        tbl[7]  = '{0, 1, 4'd4,  16'hFFFF, 16'h0000, 32'hBEEF_1234};
        tbl[8]  = '{0, 1, 4'd0,  16'h5555, 16'h0000, 32'hBEEF_1234};
        tbl[9]  = '{1, 0, 4'd1,  16'h0000, 16'h0000, 32'hBEEF_1234};
        tbl[10] = '{1, 1, 4'd2,  16'hAAAA, 16'h1234, 32'hBEEF_AAAA};
        tbl[11] = '{1, 0, 4'd2,  16'h0000, 16'hAAAA, 32'hBEEF_AAAA};
        tbl[12] = '{0, 1, 4'd1,  16'hFFFF, 16'hAAAA, 32'hBEEF_AAAA};

        io_addr = '0; io_rd = 1'b0; io_wr = 1'b0; io_wdata = '0;
        HardwareInput = 16'h0020;
        ResetButton   = 1'b0;
        repeat (3) tick();
        chk("reset rdata", 32'(io_rdata), 32'h0);
        chk("reset recv", 32'(InputRecv), 32'h0);
        chk("reset disp", DisplayOutput, 32'h0);
        ResetButton = 1'b1;
        repeat (HOLD + 4) tick();
        chk("held strobe no capture", 32'(InputRecv), 32'h0);

        // Capture latency and single pop.
        HardwareInput = 16'h000B;
        repeat (HOLD) tick();
        HardwareInput = 16'h002B;
        repeat (CAP_LAT) tick();
        chk("latency recv early", 32'(InputRecv), 32'h0);
        tick();
        chk("latency recv set", 32'(InputRecv), 32'h1);
        do_read(4'd0);
        chk("first pop data", 32'(io_rdata), 32'h000B);
        chk("first pop recv", 32'(InputRecv), 32'h0);
        HardwareInput = 16'h000B;
        repeat (HOLD) tick();

        // Overflow with five strobes into a depth-4 FIFO.
        for (int k = 1; k <= 5; k++) strobe_word(16'(k));
        do_read(4'd1);
        chk("status full ovf", 32'(io_rdata), 32'h001C);
        for (int k = 1; k <= 4; k++) begin
            do_read(4'd0);
            chk($sformatf("ovf pop %0d", k), 32'(io_rdata), 32'(k));
        end
        do_read(4'd1);
        chk("status ovf only", 32'(io_rdata), 32'h0010);
        do_write(4'd1, 16'h0001);
        do_read(4'd1);
        chk("status ovf cleared", 32'(io_rdata), 32'h0000);

        // Empty read.
        do_read(4'd0);
        chk("empty read", 32'(io_rdata), 32'h0);
        do_read(4'd1);
        chk("empty count", 32'(io_rdata), 32'h0);

        // Capture coinciding with pop on a full FIFO.
        for (int k = 6; k <= 9; k++) strobe_word(16'(k));
        do_read(4'd1);
        chk("full status", 32'(io_rdata), 32'h000C);
        HardwareInput = 16'h002A;
        repeat (CAP_LAT) tick();
        do_read(4'd0);
        chk("pop with capture full", 32'(io_rdata), 32'h0006);
        HardwareInput = 16'h000A;
        do_read(4'd1);
        chk("full no drop", 32'(io_rdata), 32'h000C);
        for (int k = 7; k <= 10; k++) begin
            do_read(4'd0);
            chk($sformatf("drain %0d", k), 32'(io_rdata), 32'(k));
        end
        repeat (HOLD) tick();

        // Capture coinciding with pop on an empty FIFO.
        HardwareInput = 16'h002C;
        repeat (CAP_LAT) tick();
        do_read(4'd0);
        chk("pop empty with capture", 32'(io_rdata), 32'h0);
        HardwareInput = 16'h000C;
        chk("stored after empty pop", 32'(InputRecv), 32'h1);
        do_read(4'd1);
        chk("count one", 32'(io_rdata), 32'h0001);
        do_read(4'd0);
        chk("no bypass word", 32'(io_rdata), 32'h000C);
        repeat (HOLD) tick();

        // Drop and overflow clear in the same cycle: set wins.
        for (int k = 1; k <= 4; k++) strobe_word(16'(k));
        HardwareInput = 16'h0025;
        repeat (CAP_LAT) tick();
        do_write(4'd1, 16'h0001);
        HardwareInput = 16'h0005;
        do_read(4'd1);
        chk("ovf set wins", 32'(io_rdata), 32'h001C);
        do_write(4'd1, 16'h0001);
        do_read(4'd1);
        chk("ovf clear later", 32'(io_rdata), 32'h000C);
        for (int k = 1; k <= 4; k++) begin
            do_read(4'd0);
            chk($sformatf("set-wins drain %0d", k), 32'(io_rdata), 32'(k));
        end

        // Register window table.
        for (int i = 0; i < 13; i++) begin
            io_rd = tbl[i].rd; io_wr = tbl[i].wr;
            io_addr = tbl[i].addr; io_wdata = tbl[i].wdata;
            tick();
            io_rd = 1'b0; io_wr = 1'b0;
            chk($sformatf("tbl%0d rdata", i), 32'(io_rdata), 32'(tbl[i].exp_rdata));
            chk($sformatf("tbl%0d disp", i), DisplayOutput, tbl[i].exp_disp);
        end

`ifdef HW_IO_DEBOUNCE_EN
        // Glitch one cycle short of the filter length, then an exact-length pulse.
        HardwareInput = 16'h0030;
        repeat (DEBOUNCE_CYCLES - 1) tick();
        HardwareInput = 16'h0010;
        repeat (CAP_LAT + 4) tick();
        chk("short glitch ignored", 32'(InputRecv), 32'h0);
        HardwareInput = 16'h0030;
        repeat (DEBOUNCE_CYCLES) tick();
        HardwareInput = 16'h0010;
        repeat (CAP_LAT + 4) tick();
        chk("debounced capture", 32'(InputRecv), 32'h1);
        do_read(4'd0);
        chk("debounced word", 32'(io_rdata), 32'h0010);
        repeat (HOLD) tick();
`endif

        // Reset with a word pending discards it.
        do_write(4'd2, 16'h5A5A);
        HardwareInput = 16'h002D;
        repeat (HOLD) tick();
        chk("pre-reset capture", 32'(InputRecv), 32'h1);
        #2 ResetButton = 1'b0;
        #1;
        chk("mid reset recv", 32'(InputRecv), 32'h0);
        chk("mid reset disp", DisplayOutput, 32'h0);
        chk("mid reset rdata", 32'(io_rdata), 32'h0);
        HardwareInput = 16'h0000;
        tick();
        ResetButton = 1'b1;
        repeat (HOLD + 3) tick();
        do_read(4'd1);
        chk("fifo discarded", 32'(io_rdata), 32'h0);

`ifndef HW_IO_DEBOUNCE_EN
        // Randomized run against the queue model.
        mq.delete();
        m_ovf = 1'b0; m_disp[0] = '0; m_disp[1] = '0; m_rdata = '0;
        for (int j = 0; j < 5; j++) h[j] = '0;
        r_sw = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) r_sw = 16'($urandom);
            r_rd   = 1'($urandom_range(0, 1));
            r_wr   = ($urandom_range(0, 3) == 0);
            r_addr = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 5));
            r_wd   = 16'($urandom);

            for (int j = 4; j > 0; j--) h[j] = h[j-1];
            h[0] = r_sw;
            pend = h[3][5] && !h[4][5];

            if (r_rd) begin
                case (r_addr)
                    4'd0:    m_rdata = (mq.size() > 0) ? mq[0] : 16'h0;
                    4'd1:    m_rdata = {11'b0, m_ovf, (mq.size() == 4), 3'(mq.size())};
                    4'd2:    m_rdata = m_disp[0];
                    4'd3:    m_rdata = m_disp[1];
                    default: m_rdata = 16'h0;
                endcase
            end
            drop = 1'b0;
            if (r_rd && r_addr == 4'd0 && mq.size() > 0) void'(mq.pop_front());
            if (pend) begin
                if (mq.size() < 4) mq.push_back(h[3] & 16'hFFDF);
                else drop = 1'b1;
            end
            if (drop) m_ovf = 1'b1;
            else if (r_wr && r_addr == 4'd1 && r_wd[0]) m_ovf = 1'b0;
            if (r_wr && r_addr == 4'd2) m_disp[0] = r_wd;
            if (r_wr && r_addr == 4'd3) m_disp[1] = r_wd;

            HardwareInput = r_sw; io_rd = r_rd; io_wr = r_wr;
            io_addr = r_addr; io_wdata = r_wd;
            tick();
            io_rd = 1'b0; io_wr = 1'b0;
            chk($sformatf("rand%0d rdata", i), 32'(io_rdata), 32'(m_rdata));
            chk($sformatf("rand%0d recv", i), 32'(InputRecv), 32'(mq.size() != 0));
            chk($sformatf("rand%0d disp", i), DisplayOutput, {m_disp[1], m_disp[0]});
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hw_io_port.md
# hw_io_port

Parametrised memory-mapped I/O port between the board switches/displays and the 16-bit multicycle processor core. Synchronises the raw `HardwareInput` switch bank, captures a word on each rising edge of a designated strobe switch into a small FIFO, and exposes it to the core through a registered read/write register window. It also holds `DISPLAYS` independent output registers that drive the board displays. It generalises the single-word input/single display path with configurable width, buffering depth, display count and overflow reporting.

## Interface

Parameters:
- `DATA_W`, 16, width of switch bank, data bus and each display register
- `FIFO_DEPTH`, 4, captured-word buffer depth (power of two, ≥2)
- `DISPLAYS`, 2, number of display output registers (1..8)
- `STROBE_BIT`, 5, index in `HardwareInput` used as the capture strobe
- `DEBOUNCE_CYCLES`, 16, stable-cycle count for the strobe when debounce is compiled in

Ports:
- `Clock`  input  1  system clock, all state on rising edge
- `ResetButton`  input  1  asynchronous, active-low reset
- `HardwareInput`  input  DATA_W  raw asynchronous switch bank
- `io_addr`  input  4  register index in the I/O window
- `io_rd`  input  1  read request, one cycle
- `io_wr`  input  1  write request, one cycle
- `io_wdata`  input  DATA_W  write data
- `io_rdata`  output  DATA_W  registered read data
- `InputRecv`  output  1  high while FIFO non-empty
- `DisplayOutput`  output  DISPLAYS*DATA_W  concatenated display registers, display 0 in LSBs

## Operation

- `HardwareInput` passes a 2-flop synchroniser; all logic uses the synchronised copy.
- Capture: rising edge of synchronised strobe bit pushes the synchronised word with the strobe bit forced to 0.
- FIFO full at capture: word dropped, sticky `ovf` set.
- Register map (`io_addr`):
  - 0 DATA: read pops head and returns it; read when empty returns 0, no pop. Writes ignored.
  - 1 STATUS: read `{.., ovf, full, count}` (count in bits [clog2(FIFO_DEPTH):0], full next, ovf above). Write with `io_wdata[0]=1` clears `ovf`.
  - 2..2+DISPLAYS-1 DISPn: write loads display n; read returns it.
  - Other addresses: read returns 0, writes ignored.
- Simultaneous capture and pop: both occur; when full, no drop and no `ovf`; when empty, pop returns 0 and the captured word is stored (no bypass).
- `io_rd` and `io_wr` in same cycle: both act; a read of the written register returns the pre-write value.
- Capture and `ovf` clear in same cycle on full FIFO: set wins (`ovf`=1).

## Timing

- Reset: `io_rdata`=0, `InputRecv`=0, `DisplayOutput`=0, FIFO empty, `ovf`=0, synchroniser and edge history 0. Reset mid-capture discards the FIFO contents.
- Read latency 1: `io_rdata` valid the cycle after `io_rd`, holds until next read.
- Display write visible on `DisplayOutput` the cycle after `io_wr`.
- Strobe rising sampled at edge N → word in FIFO and `InputRecv`=1 after edge N+3 (no debounce).
- Pop of last entry → `InputRecv`=0 after the same edge that loads `io_rdata`.
- FIFO pointers wrap modulo FIFO_DEPTH; count saturates only by the full rule.

## Configuration

- `HW_IO_DEBOUNCE_EN` defined: the synchronised strobe must hold a new level for `DEBOUNCE_CYCLES` consecutive cycles before the filtered level changes; capture occurs on the filtered rising edge (latency N+3+DEBOUNCE_CYCLES). Glitches shorter than that produce no capture.
- Undefined: no filter, capture on the raw synchronised edge; `DEBOUNCE_CYCLES` unused.

## Structure

- Package `hw_io_pkg`: register offsets (DATA=0, STATUS=1, DISP_BASE=2), STATUS bit positions, clear-ovf bit index.
- Sub-module `io_fifo`: parametrised synchronous FIFO (push, pop, data, count, full, empty); port logic, synchroniser, debounce and register decode stay in `hw_io_port`.

## Test plan

- Reset held low with switches at 0x0020 → all outputs 0; release, no capture until strobe falls and rises again.
- Set 0x000B then 0x002B → after 3 cycles `InputRecv`=1; read addr 0 → `io_rdata`=0x000B next cycle, `InputRecv`=0.
- Five strobes with depth 4 (0x21,0x22,0x23,0x24,0x25) → STATUS count=4, full=1, ovf=1; pops return 0x01,0x02,0x03,0x04; write STATUS 0x0001 → ovf=0.
- Read addr 0 while empty → `io_rdata`=0, count stays 0; capture coinciding with pop on full FIFO → count stays 4, ovf stays 0.
- Write 0x1234 to addr 2 and 0xBEEF to addr 3 → `DisplayOutput`=0xBEEF1234; read addr 3 → 0xBEEF.
- With `HW_IO_DEBOUNCE_EN`: strobe pulse of DEBOUNCE_CYCLES-1 cycles → no capture; pulse of DEBOUNCE_CYCLES cycles → one capture.
